// File: rtl/mem_arb_pkg.sv
// Shared defaults, FSM state encoding and beat-counter sizing for the memory request arbiter.
package mem_arb_pkg;

    localparam int ADDR_BITS_DEF  = 26;
    localparam int TAG_BITS_DEF   = 5;
    localparam int DATA_BITS_DEF  = 128;
    localparam int DATA_BEATS_DEF = 4;
    localparam int BEAT_BITS_DEF  = $clog2(DATA_BEATS_DEF);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WDATA = 1'b1
    } state_t;

    // A single-beat burst still needs a 1-bit counter to keep the vector legal.
    function automatic int beat_bits(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Two-way grant selection: round-robin when MEM_ARB_RR_EN is defined, otherwise client 0 wins ties.
module mem_arb_picker (
`ifdef MEM_ARB_RR_EN
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
`endif
    input  logic [1:0] req,
    output logic       grant
);

`ifdef MEM_ARB_RR_EN
    logic ptr;

    always_comb begin
        grant = 1'b0;
        unique case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ptr;
            default: grant = 1'b0;
        endcase
    end

    // After every accepted command the other client gets first claim on the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= 1'b0;
        else if (advance)
            ptr <= ~grant;
    end
`else
    assign grant = ~req[0] & req[1];
`endif

endmodule

// File: rtl/mem_req_arbiter.sv
// Two-client memory request arbiter with write-burst ownership and tag-routed responses.
// Build option: MEM_ARB_RR_EN selects round-robin grant (fixed client-0 priority otherwise).
//
// state    | meaning
// ST_IDLE  | commands pass through from the granted client; no write data moves
// ST_WDATA | owner's write beats forwarded; all commands held off
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_BITS  = ADDR_BITS_DEF,
    parameter int TAG_BITS   = TAG_BITS_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int DATA_BEATS = DATA_BEATS_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic [1:0]                  c_cmd_valid,
    output logic [1:0]                  c_cmd_ready,
    input  logic [2*ADDR_BITS-1:0]      c_cmd_addr,
    input  logic [2*(TAG_BITS-1)-1:0]   c_cmd_tag,
    input  logic [1:0]                  c_cmd_rw,

    input  logic [1:0]                  c_data_valid,
    output logic [1:0]                  c_data_ready,
    input  logic [2*DATA_BITS-1:0]      c_data_bits,

    output logic [1:0]                  c_resp_valid,
    input  logic [1:0]                  c_resp_ready,
    output logic [DATA_BITS-1:0]        c_resp_data,
    output logic [TAG_BITS-2:0]         c_resp_tag,

    output logic                        m_cmd_valid,
    input  logic                        m_cmd_ready,
    output logic [ADDR_BITS-1:0]        m_cmd_addr,
    output logic [TAG_BITS-1:0]         m_cmd_tag,
    output logic                        m_cmd_rw,

    output logic                        m_data_valid,
    input  logic                        m_data_ready,
    output logic [DATA_BITS-1:0]        m_data_bits,

    input  logic                        m_resp_valid,
    output logic                        m_resp_ready,
    input  logic [DATA_BITS-1:0]        m_resp_data,
    input  logic [TAG_BITS-1:0]         m_resp_tag
);

    localparam int CT       = TAG_BITS - 1;
    localparam int CNT_BITS = beat_bits(DATA_BEATS);
    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(DATA_BEATS - 1);

    state_t              state, state_nxt;
    logic                owner, owner_nxt;
    logic [CNT_BITS-1:0] beat_cnt, beat_cnt_nxt;

    logic grant;
    logic idle;
    logic wdata;
    logic cmd_fire;
    logic data_fire;
    logic resp_id;

    mem_arb_picker u_picker (
`ifdef MEM_ARB_RR_EN
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (cmd_fire),
`endif
        .req     (c_cmd_valid),
        .grant   (grant)
    );

    // Handshake outputs are qualified by rst_n so nothing leaks through while reset is held.
    assign idle  = rst_n && (state == ST_IDLE);
    assign wdata = rst_n && (state == ST_WDATA);

    assign m_cmd_valid = idle & (|c_cmd_valid);
    assign m_cmd_addr  = grant ? c_cmd_addr[2*ADDR_BITS-1:ADDR_BITS] : c_cmd_addr[ADDR_BITS-1:0];
    assign m_cmd_tag   = {grant, (grant ? c_cmd_tag[2*CT-1:CT] : c_cmd_tag[CT-1:0])};
    assign m_cmd_rw    = c_cmd_rw[grant];
    assign c_cmd_ready = idle ? (grant ? {m_cmd_ready, 1'b0} : {1'b0, m_cmd_ready}) : 2'b00;
    assign cmd_fire    = m_cmd_valid & m_cmd_ready;

    assign m_data_valid = wdata & c_data_valid[owner];
    assign m_data_bits  = owner ? c_data_bits[2*DATA_BITS-1:DATA_BITS] : c_data_bits[DATA_BITS-1:0];
    assign c_data_ready = wdata ? (owner ? {m_data_ready, 1'b0} : {1'b0, m_data_ready}) : 2'b00;
    assign data_fire    = m_data_valid & m_data_ready;

    assign resp_id      = m_resp_tag[TAG_BITS-1];
    assign c_resp_valid = (rst_n & m_resp_valid) ? (resp_id ? 2'b10 : 2'b01) : 2'b00;
    assign m_resp_ready = rst_n & c_resp_ready[resp_id];
    assign c_resp_data  = m_resp_data;
    assign c_resp_tag   = m_resp_tag[TAG_BITS-2:0];

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        beat_cnt_nxt = beat_cnt;
        unique case (state)
            ST_IDLE: begin
                if (cmd_fire && m_cmd_rw) begin
                    state_nxt    = ST_WDATA;
                    owner_nxt    = grant;
                    beat_cnt_nxt = '0;
                end
            end
            ST_WDATA: begin
                if (data_fire) begin
                    if (beat_cnt == LAST_BEAT) begin
                        state_nxt    = ST_IDLE;
                        beat_cnt_nxt = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            owner    <= 1'b0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter (expectations follow MEM_ARB_RR_EN if defined).
module tb_mem_req_arbiter;

    localparam int A = 26;
    localparam int T = 5;
    localparam int D = 128;
    localparam int B = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [1:0]         c_cmd_valid, c_cmd_ready, c_cmd_rw;
    logic [2*A-1:0]     c_cmd_addr;
    logic [2*(T-1)-1:0] c_cmd_tag;
    logic [1:0]         c_data_valid, c_data_ready;
    logic [2*D-1:0]     c_data_bits;
    logic [1:0]         c_resp_valid, c_resp_ready;
    logic [D-1:0]       c_resp_data;
    logic [T-2:0]       c_resp_tag;
    logic               m_cmd_valid, m_cmd_ready, m_cmd_rw;
    logic [A-1:0]       m_cmd_addr;
    logic [T-1:0]       m_cmd_tag;
    logic               m_data_valid, m_data_ready;
    logic [D-1:0]       m_data_bits;
    logic               m_resp_valid, m_resp_ready;
    logic [D-1:0]       m_resp_data;
    logic [T-1:0]       m_resp_tag;

    int checks = 0;
    int errors = 0;

    mem_req_arbiter #(.ADDR_BITS(A), .TAG_BITS(T), .DATA_BITS(D), .DATA_BEATS(B)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_cmd_valid(c_cmd_valid), .c_cmd_ready(c_cmd_ready), .c_cmd_addr(c_cmd_addr),
        .c_cmd_tag(c_cmd_tag), .c_cmd_rw(c_cmd_rw),
        .c_data_valid(c_data_valid), .c_data_ready(c_data_ready), .c_data_bits(c_data_bits),
        .c_resp_valid(c_resp_valid), .c_resp_ready(c_resp_ready), .c_resp_data(c_resp_data),
        .c_resp_tag(c_resp_tag),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_addr(m_cmd_addr),
        .m_cmd_tag(m_cmd_tag), .m_cmd_rw(m_cmd_rw),
        .m_data_valid(m_data_valid), .m_data_ready(m_data_ready), .m_data_bits(m_data_bits),
        .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready), .m_resp_data(m_resp_data),
        .m_resp_tag(m_resp_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [D-1:0] obs, input logic [D-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_all_quiet(input string tag);
        chk({tag, " m_cmd_valid"},  D'(m_cmd_valid),  '0);
        chk({tag, " c_cmd_ready"},  D'(c_cmd_ready),  '0);
        chk({tag, " m_data_valid"}, D'(m_data_valid), '0);
        chk({tag, " c_data_ready"}, D'(c_data_ready), '0);
        chk({tag, " c_resp_valid"}, D'(c_resp_valid), '0);
        chk({tag, " m_resp_ready"}, D'(m_resp_ready), '0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    logic         exp_g;
    logic [D-1:0] beat_pat;

    initial begin
        rst_n        = 1'b0;
        c_cmd_valid  = 2'b11;
        c_cmd_addr   = {26'h0000ABC, 26'h0000123};
        c_cmd_tag    = {4'hA, 4'h3};
        c_cmd_rw     = 2'b00;
        c_data_valid = 2'b11;
        c_data_bits  = {128'hB000, 128'hDEAD};
        c_resp_ready = 2'b11;
        m_cmd_ready  = 1'b1;
        m_data_ready = 1'b1;
        m_resp_valid = 1'b1;
        m_resp_data  = 128'h5A5A;
        m_resp_tag   = 5'b10110;
        settle();
        chk_all_quiet("reset");
        tick();
        tick();

        // Single client-0 read passes straight through.
        rst_n       = 1'b1;
        m_resp_valid = 1'b0;
        c_cmd_valid = 2'b01;
        settle();
        chk("rd0 m_cmd_valid", D'(m_cmd_valid), D'(1'b1));
        chk("rd0 m_cmd_addr",  D'(m_cmd_addr),  D'(26'h123));
        chk("rd0 m_cmd_tag",   D'(m_cmd_tag),   D'(5'b00011));
        chk("rd0 m_cmd_rw",    D'(m_cmd_rw),    D'(1'b0));
        chk("rd0 c_cmd_ready", D'(c_cmd_ready), D'(2'b01));
        chk("rd0 m_data_valid", D'(m_data_valid), '0);
        tick();
        chk("rd0 stays idle", D'(m_cmd_valid), D'(1'b1));

        // Contending reads from a fresh pointer.
        pulse_reset();
        c_cmd_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_g = (i % 2) == 1;
`else
            exp_g = 1'b0;
`endif
            settle();
            chk($sformatf("tie%0d m_cmd_tag", i), D'(m_cmd_tag),
                D'(exp_g ? 5'b11010 : 5'b00011));
            chk($sformatf("tie%0d c_cmd_ready", i), D'(c_cmd_ready),
                D'(exp_g ? 2'b10 : 2'b01));
            chk($sformatf("tie%0d m_cmd_addr", i), D'(m_cmd_addr),
                D'(exp_g ? 26'hABC : 26'h123));
            tick();
        end

        // Client-1 write burst while client 0 waits with a read.
        c_cmd_valid  = 2'b10;
        c_cmd_rw     = 2'b10;
        c_data_valid = 2'b11;
        settle();
        chk("wr1 m_cmd_tag",     D'(m_cmd_tag),    D'(5'b11010));
        chk("wr1 m_cmd_rw",      D'(m_cmd_rw),     D'(1'b1));
        chk("wr1 no same-cycle data", D'(m_data_valid), '0);
        chk("wr1 c_data_ready idle",  D'(c_data_ready), '0);
        tick();
        c_cmd_valid = 2'b01;
        c_cmd_rw    = 2'b00;
        for (int k = 0; k < B; k++) begin
            beat_pat    = 128'hB000 + D'(k);
            c_data_bits = {beat_pat, 128'hDEAD};
            if (k == 2) begin
                m_data_ready = 1'b0;
                settle();
                chk("wr1 stall c_data_ready", D'(c_data_ready), '0);
                chk("wr1 stall m_data_valid", D'(m_data_valid), D'(1'b1));
                tick();
                m_data_ready = 1'b1;
            end
            settle();
            chk($sformatf("beat%0d m_cmd_valid", k),  D'(m_cmd_valid),  '0);
            chk($sformatf("beat%0d c_cmd_ready", k),  D'(c_cmd_ready),  '0);
            chk($sformatf("beat%0d m_data_valid", k), D'(m_data_valid), D'(1'b1));
            chk($sformatf("beat%0d c_data_ready", k), D'(c_data_ready), D'(2'b10));
            chk($sformatf("beat%0d m_data_bits", k),  m_data_bits,      beat_pat);
            tick();
        end
        settle();
        chk("post-burst m_cmd_valid",  D'(m_cmd_valid),  D'(1'b1));
        chk("post-burst m_cmd_tag",    D'(m_cmd_tag),    D'(5'b00011));
        chk("post-burst c_cmd_ready",  D'(c_cmd_ready),  D'(2'b01));
        chk("post-burst m_data_valid", D'(m_data_valid), '0);

        // Response routing, concurrent with that read command.
        m_resp_valid = 1'b1;
        m_resp_tag   = 5'b10110;
        c_resp_ready = 2'b01;
        settle();
        chk("resp1 c_resp_valid", D'(c_resp_valid), D'(2'b10));
        chk("resp1 c_resp_tag",   D'(c_resp_tag),   D'(4'b0110));
        chk("resp1 m_resp_ready", D'(m_resp_ready), D'(1'b0));
        chk("resp1 c_resp_data",  c_resp_data,      128'h5A5A);
        c_resp_ready = 2'b10;
        settle();
        chk("resp1 ready m_resp_ready", D'(m_resp_ready), D'(1'b1));
        chk("resp with cmd c_cmd_ready", D'(c_cmd_ready), D'(2'b01));
        m_resp_tag   = 5'b00101;
        c_resp_ready = 2'b01;
        settle();
        chk("resp0 c_resp_valid", D'(c_resp_valid), D'(2'b01));
        chk("resp0 c_resp_tag",   D'(c_resp_tag),   D'(4'b0101));
        chk("resp0 m_resp_ready", D'(m_resp_ready), D'(1'b1));
        tick();

        // Reset in the middle of a client-0 write burst.
        c_cmd_valid  = 2'b01;
        c_cmd_rw     = 2'b01;
        tick();
        c_cmd_valid  = 2'b00;
        c_cmd_rw     = 2'b00;
        settle();
        chk("wr0 owner c_data_ready", D'(c_data_ready), D'(2'b01));
        chk("wr0 owner m_data_bits",  m_data_bits,      128'hDEAD);
        tick();
        tick();
        c_cmd_valid  = 2'b01;
        c_resp_ready = 2'b11;
        m_resp_valid = 1'b1;
        rst_n        = 1'b0;
        settle();
        chk_all_quiet("midburst reset");
        tick();
        rst_n        = 1'b1;
        c_cmd_valid  = 2'b00;
        m_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("abandon%0d m_data_valid", i), D'(m_data_valid), '0);
            chk($sformatf("abandon%0d c_data_ready", i), D'(c_data_ready), '0);
            tick();
        end
        c_cmd_valid = 2'b01;
        c_cmd_rw    = 2'b01;
        settle();
        chk("rewrite cmd m_data_valid", D'(m_data_valid), '0);
        tick();
        c_cmd_valid = 2'b00;
        settle();
        chk("rewrite beat m_data_valid", D'(m_data_valid), D'(1'b1));
        chk("rewrite beat c_data_ready", D'(c_data_ready), D'(2'b01));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
